// File: rtl/mem_burst_adapter_pkg.sv
// Shared constants for the 512-bit block to 32-bit word-beat adapter.
// Holds block geometry, counter width and the FSM state encoding.
package mem_burst_adapter_pkg;

  localparam int BLOCK_WORDS = 16;
  localparam int BLOCK_W     = 512;
  localparam int OFFS_W      = 6;
  localparam int CNT_W       = 5;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WR_BURST = 2'd1;
  localparam logic [1:0] S_RD_BURST = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  // Bit offset of word idx inside a block.
  function automatic logic [8:0] word_lsb(input logic [3:0] idx);
    return {idx, 5'b0_0000};
  endfunction

endpackage

// File: rtl/mem_burst_adapter_burst_counter.sv
// Beat counter 0..16 with terminal flag; holds at 16 so a burst never wraps.
// Latency: count visible the cycle after inc; no backpressure of its own.
module burst_counter
  import mem_burst_adapter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             term
);

  assign term = (cnt == CNT_W'(BLOCK_WORDS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !term) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_burst_adapter.sv
// Splits 64-byte block reads/writes into 16 ascending 32-bit bus beats.
// Latency: 17 (write) / 18 (read) cycles at full grant; stalls beat-by-beat on bus_gnt.
module mem_burst_adapter
  import mem_burst_adapter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [ADDR_W-1:0]  mem_addr,
  input  logic [BLOCK_W-1:0] mem_write_data,
  output logic [BLOCK_W-1:0] mem_read_data,
  output logic               mem_ready,
  output logic               bus_req,
  output logic               bus_we,
  output logic [ADDR_W-1:0]  bus_addr,
  output logic [31:0]        bus_wdata,
  input  logic               bus_gnt,
  input  logic               bus_rvalid,
  input  logic [31:0]        bus_rdata,
  output logic               err
);

  logic [1:0]         state;
  logic [ADDR_W-1:0]  base;
  logic [ADDR_W-1:0]  base_aligned;
  logic [BLOCK_W-1:0] wbuf;
  logic [BLOCK_W-1:0] rbuf;
  logic [BLOCK_W-1:0] rbuf_next;
  logic [CNT_W-1:0]   iss_cnt;
  logic [CNT_W-1:0]   rsp_cnt;
  logic               iss_term;
  logic               rsp_term;
  logic               in_burst;
  logic               is_wr;
  logic               beat_acc;
  logic               rsp_acc;
  logic               err_set;

  assign base_aligned = mem_addr & ~ADDR_W'((2 ** OFFS_W) - 1);
  assign in_burst     = (state == S_WR_BURST) || (state == S_RD_BURST);
  assign is_wr        = (state == S_WR_BURST);

  assign bus_req   = in_burst && !iss_term;
  assign bus_we    = bus_req && is_wr;
  assign bus_addr  = bus_req ? base + ADDR_W'({iss_cnt[3:0], 2'b00}) : '0;
  assign bus_wdata = bus_we ? wbuf[word_lsb(iss_cnt[3:0]) +: 32] : '0;
  assign mem_ready = (state == S_DONE);

  assign beat_acc = bus_req && bus_gnt;
  // A response is only legal while a read beat is outstanding.
  assign rsp_acc  = bus_rvalid && (state == S_RD_BURST) && !rsp_term && (rsp_cnt < iss_cnt);

  assign err_set = ((mem_read || mem_write) && (state != S_IDLE)) ||
                   (mem_read && mem_write && (state == S_IDLE)) ||
                   (bus_rvalid && !rsp_acc);

  always_comb begin
    rbuf_next = rbuf;
    rbuf_next[word_lsb(rsp_cnt[3:0]) +: 32] = bus_rdata;
  end

  burst_counter u_iss_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (!in_burst),
    .inc  (beat_acc),
    .cnt  (iss_cnt),
    .term (iss_term)
  );

  burst_counter u_rsp_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (!in_burst),
    .inc  (rsp_acc),
    .cnt  (rsp_cnt),
    .term (rsp_term)
  );

  // Reads assemble in rbuf; mem_read_data only changes when the last word lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      base          <= '0;
      wbuf          <= '0;
      rbuf          <= '0;
      mem_read_data <= '0;
      err           <= 1'b0;
    end else begin
      if (err_set) begin
        err <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (mem_write) begin
            base  <= base_aligned;
            wbuf  <= mem_write_data;
            state <= S_WR_BURST;
          end else if (mem_read) begin
            base  <= base_aligned;
            state <= S_RD_BURST;
          end
        end
        S_WR_BURST: begin
          if (beat_acc && (iss_cnt == CNT_W'(BLOCK_WORDS - 1))) begin
            state <= S_DONE;
          end
        end
        S_RD_BURST: begin
          if (rsp_acc) begin
            rbuf <= rbuf_next;
            if (rsp_cnt == CNT_W'(BLOCK_WORDS - 1)) begin
              mem_read_data <= rbuf_next;
              state         <= S_DONE;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_burst_adapter.sv
// Directed bench for mem_burst_adapter: bus model with configurable grant/response timing.
module tb_mem_burst_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_addr;
  logic [511:0] mem_write_data;
  logic [511:0] mem_read_data;
  logic         mem_ready;
  logic         bus_req;
  logic         bus_we;
  logic [31:0]  bus_addr;
  logic [31:0]  bus_wdata;
  logic         bus_gnt;
  logic         bus_rvalid;
  logic [31:0]  bus_rdata;
  logic         err;

  int n_chk  = 0;
  int n_pass = 0;

  int ready_cyc, n_ready, n_beats, n_rsp, extra_ready, extra_req;

  always #5 clk = ~clk;

  mem_burst_adapter #(.ADDR_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .mem_ready      (mem_ready),
    .bus_req        (bus_req),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_gnt        (bus_gnt),
    .bus_rvalid     (bus_rvalid),
    .bus_rdata      (bus_rdata),
    .err            (err)
  );

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [511:0] read_block(input logic [31:0] base);
    logic [511:0] blk;
    for (int i = 0; i < 16; i++) blk[32*i +: 32] = (base + 32'(4 * i)) ^ 32'h5555_5555;
    return blk;
  endfunction

  // Cycle 0 is the request pulse; all observation and driving happens on negedge.
  task automatic run_burst(input bit do_wr, input bit do_rd, input logic [31:0] addr,
                           input bit gnt_toggle, input int rdelay, input int abort_beat);
    int          q_due[$];
    logic [31:0] q_dat[$];
    logic [31:0] exp_base;
    int          cyc;
    exp_base  = addr & 32'hFFFF_FFC0;
    ready_cyc = -1;
    n_ready   = 0;
    n_beats   = 0;
    n_rsp     = 0;
    for (int i = 0; i < 16; i++) mem_write_data[32*i +: 32] = 32'hA000_0000 + 32'(i);
    @(negedge clk);
    mem_addr  = addr;
    mem_write = do_wr;
    mem_read  = do_rd;
    @(negedge clk);
    mem_write = 1'b0;
    mem_read  = 1'b0;
    cyc = 1;
    while (cyc < 200) begin
      if (mem_ready) begin
        n_ready++;
        if (ready_cyc < 0) ready_cyc = cyc;
      end
      bus_gnt    = gnt_toggle ? ((cyc % 2) == 1) : 1'b1;
      bus_rvalid = 1'b0;
      bus_rdata  = '0;
      if (q_due.size() > 0 && q_due[0] <= cyc) begin
        bus_rvalid = 1'b1;
        bus_rdata  = q_dat.pop_front();
        void'(q_due.pop_front());
        n_rsp++;
      end
      if (bus_req) begin
        check("beat_idx_lt16", (n_beats < 16), 1'b1);
        check("beat_addr", bus_addr, exp_base + 32'(4 * n_beats));
        check("beat_we", bus_we, do_wr);
        if (do_wr) check("beat_wdata", bus_wdata, 32'hA000_0000 + 32'(n_beats));
      end
      if (bus_req && bus_gnt) begin
        if (!do_wr) begin
          q_due.push_back(cyc + rdelay);
          q_dat.push_back(bus_addr ^ 32'h5555_5555);
        end
        n_beats++;
        if (n_beats == abort_beat + 1) begin
          @(posedge clk);
          #1;
          rst        = 1'b1;
          bus_gnt    = 1'b0;
          bus_rvalid = 1'b0;
          #1;
          check("rst_async_req", bus_req, 1'b0);
          check("rst_async_ready", mem_ready, 1'b0);
          @(negedge clk);
          rst = 1'b0;
          break;
        end
      end
      @(negedge clk);
      cyc++;
      if (ready_cyc >= 0 && cyc > ready_cyc + 3) break;
    end
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
  endtask

  task automatic spurious_rvalid();
    @(negedge clk);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_addr = '0;
    mem_write_data = '0;
    bus_gnt = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_bus_req", bus_req, 1'b0);
    check("rst_bus_we", bus_we, 1'b0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    check("rst_mem_ready", mem_ready, 1'b0);
    check("rst_read_data", mem_read_data, 512'h0);
    check("rst_err", err, 1'b0);
    rst = 1'b0;

    // Full-rate write burst
    run_burst(1'b1, 1'b0, 32'h0000_1040, 1'b0, 1, -1);
    check("wr_ready_cyc", ready_cyc, 17);
    check("wr_ready_cnt", n_ready, 1);
    check("wr_beats", n_beats, 16);
    check("wr_err", err, 1'b0);

    // Full-rate read burst, response one cycle after grant
    run_burst(1'b0, 1'b1, 32'h0000_2000, 1'b0, 1, -1);
    check("rd_ready_cyc", ready_cyc, 18);
    check("rd_ready_cnt", n_ready, 1);
    check("rd_rsp", n_rsp, 16);
    check("rd_data", mem_read_data, read_block(32'h0000_2000));
    check("rd_err", err, 1'b0);

    // Grant every other cycle, response three cycles after grant
    run_burst(1'b0, 1'b1, 32'h0000_4000, 1'b1, 3, -1);
    check("rdt_beats", n_beats, 16);
    check("rdt_rsp", n_rsp, 16);
    check("rdt_ready_cnt", n_ready, 1);
    check("rdt_ready_cyc", ready_cyc, 35);
    check("rdt_data", mem_read_data, read_block(32'h0000_4000));
    check("rdt_err", err, 1'b0);

    // Unaligned address aligns down; a write leaves read data untouched
    run_burst(1'b1, 1'b0, 32'h0000_307C, 1'b0, 1, -1);
    check("una_ready_cyc", ready_cyc, 17);
    check("una_beats", n_beats, 16);
    check("una_hold_rdata", mem_read_data, read_block(32'h0000_4000));
    check("una_err", err, 1'b0);

    // Read and write together: executes as write, flags error
    run_burst(1'b1, 1'b1, 32'h0000_1000, 1'b0, 1, -1);
    check("both_ready_cyc", ready_cyc, 17);
    check("both_beats", n_beats, 16);
    check("both_err", err, 1'b1);
    spurious_rvalid();
    check("idle_rvalid_err_sticky", err, 1'b1);
    check("idle_rvalid_no_req", bus_req, 1'b0);

    // Reset after beat 7 of a read: burst abandoned, no completion pulse
    run_burst(1'b0, 1'b1, 32'h0000_5000, 1'b0, 1, 7);
    check("abort_no_ready", n_ready, 0);
    extra_ready = 0;
    extra_req   = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_ready) extra_ready++;
      if (bus_req) extra_req++;
    end
    check("abort_ready_after", extra_ready, 0);
    check("abort_req_after", extra_req, 0);
    check("abort_err_cleared", err, 1'b0);
    check("abort_rdata_cleared", mem_read_data, 512'h0);

    run_burst(1'b1, 1'b0, 32'h0000_6000, 1'b0, 1, -1);
    check("post_wr_ready_cyc", ready_cyc, 17);
    check("post_wr_ready_cnt", n_ready, 1);
    check("post_wr_beats", n_beats, 16);
    check("post_wr_err", err, 1'b0);

    spurious_rvalid();
    check("idle_rvalid_sets_err", err, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_burst_adapter.md
MEM_BURST_ADAPTER -- requirements
Module: mem_burst_adapter

Interface
REQ-001 Parameter: BLOCK_WORDS, 16, 32-bit words per cache block (512 bits); fixed, not overridable.
REQ-002 Parameter: ADDR_W, 32, byte address width.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 mem_read  input  1  one-cycle pulse; requests a 64-byte block read.
REQ-006 mem_write  input  1  one-cycle pulse; requests a 64-byte block write.
REQ-007 mem_addr  input  32  block byte address; sampled with the request pulse.
REQ-008 mem_write_data  input  512  block write data; sampled with the request pulse.
REQ-009 mem_read_data  output  512  assembled read block.
REQ-010 mem_ready  output  1  one-cycle completion pulse for the current block request.
REQ-011 bus_req  output  1  word-beat request valid.
REQ-012 bus_we  output  1  beat is a write (1) or a read (0).
REQ-013 bus_addr  output  32  beat byte address.
REQ-014 bus_wdata  output  32  beat write data.
REQ-015 bus_gnt  input  1  beat accepted when bus_req && bus_gnt.
REQ-016 bus_rvalid  input  1  read response valid; responses return in issue order.
REQ-017 bus_rdata  input  32  read response data.
REQ-018 err  output  1  sticky protocol-error flag; cleared only by rst.

Function
REQ-019 States SHALL be IDLE, WR_BURST, RD_BURST and DONE.
REQ-020 IDLE: on mem_write latch base={mem_addr[31:6],6'b0} and data, go WR_BURST; on mem_read latch base, go RD_BURST.
REQ-021 mem_read && mem_write in the same cycle SHALL be treated as a write and SHALL set err.
REQ-022 Requests arriving outside IDLE SHALL be ignored and SHALL set err.
REQ-023 Beat i (0..15) SHALL use bus_addr=base+4*i and word bits [32*i+31:32*i], in ascending order.
REQ-024 bus_req SHALL assert in the cycle after the request is latched, with bus_we/addr/wdata stable until granted.
REQ-025 WR_BURST: the issue counter SHALL advance on each grant; after grant of beat 15 go to DONE (posted writes).
REQ-026 RD_BURST: issue and response counters SHALL run independently; beats SHALL keep issuing while responses are pending; bus_req SHALL drop after beat 15 is granted.
REQ-027 Each bus_rvalid SHALL store bus_rdata into word[rsp_cnt]; after response 15, go to DONE.
REQ-028 bus_rvalid with no outstanding beat, or outside RD_BURST, SHALL be ignored and SHALL set err.
REQ-029 DONE SHALL assert mem_ready for exactly one cycle, then return to IDLE.
REQ-030 A new request SHALL be accepted in IDLE only; minimum gap between mem_ready and the next acceptance is 0 cycles.
REQ-031 mem_read_data SHALL update only during read bursts and SHALL hold its value until the next read completes.
REQ-032 Latency with bus_gnt=1 and rvalid one cycle after grant: write mem_ready 17 cycles after the request pulse; read mem_ready 18 cycles after the request pulse.
REQ-033 Counters SHALL be 5 bits wide so that the terminal value 16 is distinct from 0; no wrap within a burst.

Reset
REQ-034 rst SHALL asynchronously force IDLE, counters 0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, mem_ready=0, mem_read_data=0, err=0.
REQ-035 rst mid-burst SHALL abandon the burst without any mem_ready pulse; in-flight bus responses after reset release SHALL set err.

Structure
REQ-036 The shared package SHALL hold BLOCK_WORDS, the block width (512), the offset width (6) and the state encoding.
REQ-037 A word-order beat_fifo-free design SHALL be used; one sub-module, burst_counter (5-bit issue/response counter with terminal flag), is natural and SHALL be instantiated twice.

Verification
REQ-038 Write at 0x0000_1040 with word i=0xA000_0000+i and bus_gnt=1 -> beats at 0x1040..0x107C carry the matching data; mem_ready in cycle 17; err=0.
REQ-039 Read at 0x0000_2000 with a memory model returning addr^0x5555_5555 one cycle after grant -> mem_read_data word i = (0x2000+4i)^0x5555_5555; mem_ready in cycle 18.
REQ-040 Read with bus_gnt toggling 1/0 and rvalid delayed 3 cycles -> 16 grants, 16 responses, correct block, single mem_ready pulse.
REQ-041 Unaligned address 0x0000_307C -> beats start at 0x3040.
REQ-042 mem_read and mem_write pulsed together -> write burst executes, err=1; spurious bus_rvalid in IDLE -> ignored, err stays 1.
REQ-043 rst asserted at beat 7 of a read -> immediate IDLE, no mem_ready; a following write completes normally.
